// File: rtl/mem_responder.sv
// Memory-side responder: unified instruction/data RAM plus two memory-mapped I/O
// words, a programmable number of wait states and a one-cycle Ready completion pulse.
module mem_responder #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = {{(ADDR_W-1){1'b1}}, 1'b0},
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] IOIn,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic [DATA_W-1:0] IOOut,
  output logic              Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam bit         NO_WAIT   = (WAIT_CYCLES == 32'sd0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 32'sd1);

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic                wr_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                ready_r;
  logic                busy_r;
  logic [DATA_W-1:0]   ioout_r;
  logic                err_r;
  logic [DATA_W-1:0]   mem_r [0:(32'sd1 << ADDR_W) - 32'sd1];

  logic                accept_s;
  logic                conflict_s;
  logic                commit_s;
  logic [ADDR_W-1:0]   req_addr_s;
  logic [DATA_W-1:0]   req_data_s;
  logic                req_wr_s;
  logic [DATA_W-1:0]   rd_val_s;

  // Next-state logic: accept exactly one strobe in IDLE, count waits, then hold until strobes drop
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    conflict_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (MemRead && MemWrite) begin
          conflict_s = 1'b1;
        end else if (MemRead || MemWrite) begin
          accept_s = 1'b1;
          if (NO_WAIT) begin
            state_s = S_DONE;
          end else begin
            state_s = S_WAIT;
            cnt_s   = WAIT_INIT;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_DONE: state_s = S_HOLD;
      S_HOLD: begin
        if (!MemRead && !MemWrite) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the acceptance edge, so bypass the latches
  always_comb begin
    commit_s   = (state_s == S_DONE) && (state_r != S_DONE);
    req_addr_s = accept_s ? Addr      : addr_r;
    req_data_s = accept_s ? WriteData : data_r;
    req_wr_s   = accept_s ? MemWrite  : wr_r;
    if (req_addr_s == IO_IN_ADDR) begin
      rd_val_s = IOIn;
    end else if (req_addr_s == IO_OUT_ADDR) begin
      rd_val_s = ioout_r;
    end else begin
      rd_val_s = mem_r[req_addr_s];
    end
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      wr_r    <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      ioout_r <= {DATA_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_s == S_DONE);
      busy_r  <= (state_s != S_IDLE);
      if (accept_s) begin
        addr_r <= Addr;
        data_r <= WriteData;
        wr_r   <= MemWrite;
      end
      if (conflict_s) begin
        err_r <= 1'b1;
      end
      if (commit_s && req_wr_s && (req_addr_s == IO_OUT_ADDR)) begin
        ioout_r <= req_data_s;
      end
      if (commit_s && !req_wr_s) begin
        rdata_r <= rd_val_s;
      end
    end
  end

  // RAM write port; contents survive reset, but an aborted write never lands
  always_ff @(posedge CLK) begin
    if (Reset && commit_s && req_wr_s &&
        (req_addr_s != IO_IN_ADDR) && (req_addr_s != IO_OUT_ADDR)) begin
      mem_r[req_addr_s] <= req_data_s;
    end
  end

  assign ReadData = rdata_r;
  assign Ready    = ready_r;
  assign Busy     = busy_r;
  assign IOOut    = ioout_r;
  assign Err      = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: three responders (0, 1 and 3 wait states) checked
// against a transaction-level model of RAM, IOOut, Err and ReadData.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [2:0]  mr, mw, rdy, bsy, err;
  logic [7:0]  Addr;
  logic [15:0] WriteData, IOIn;
  logic [15:0] rdat [3];
  logic [15:0] iout [3];

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_m   [3][256];
  bit          mem_v   [3][256];
  logic [15:0] ioout_m [3];
  bit          err_m   [3];
  logic [15:0] rd_m    [3];

  always #5 CLK = ~CLK;

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .Reset(Reset), .MemRead(mr[0]), .MemWrite(mw[0]), .Addr(Addr),
    .WriteData(WriteData), .IOIn(IOIn), .ReadData(rdat[0]), .Ready(rdy[0]),
    .Busy(bsy[0]), .IOOut(iout[0]), .Err(err[0]));
  mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .CLK(CLK), .Reset(Reset), .MemRead(mr[1]), .MemWrite(mw[1]), .Addr(Addr),
    .WriteData(WriteData), .IOIn(IOIn), .ReadData(rdat[1]), .Ready(rdy[1]),
    .Busy(bsy[1]), .IOOut(iout[1]), .Err(err[1]));
  mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .CLK(CLK), .Reset(Reset), .MemRead(mr[2]), .MemWrite(mw[2]), .Addr(Addr),
    .WriteData(WriteData), .IOIn(IOIn), .ReadData(rdat[2]), .Ready(rdy[2]),
    .Busy(bsy[2]), .IOOut(iout[2]), .Err(err[2]));

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  // One complete transaction on responder i with its strobe held for `hold` cycles.
  task automatic do_txn(input int i, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, input int hold);
    int first, nrdy, idle_c, exp_idle;
    logic [15:0] exp;
    exp = (a == 8'hFE) ? IOIn : ((a == 8'hFF) ? ioout_m[i] : mem_m[i][a]);
    exp_idle = (wc(i) + 2 > hold) ? wc(i) + 2 : hold;
    Addr = a; WriteData = d; mr[i] = !wr; mw[i] = wr;
    @(posedge CLK);
    first = -1; nrdy = 0; idle_c = -1;
    for (int c = 0; c < 40 && idle_c < 0; c++) begin
      #1;
      Addr = 8'($urandom); WriteData = 16'($urandom);
      if (c + 1 >= hold) begin mr[i] = 1'b0; mw[i] = 1'b0; end
      @(negedge CLK);
      if (rdy[i] === 1'b1) begin
        nrdy++;
        if (first < 0) first = c;
        if (!wr) begin
          checks++;
          if (rdat[i] !== exp) begin
            failures++;
            $display("FAIL read_data dut%0d addr=%h got=%h exp=%h", i, a, rdat[i], exp);
          end
        end
      end
      if (bsy[i] !== 1'b1) idle_c = c;
      if (idle_c < 0) @(posedge CLK);
    end
    checks++;
    if (first !== wc(i)) begin
      failures++;
      $display("FAIL ready_latency dut%0d got=%0d exp=%0d", i, first, wc(i));
    end
    checks++;
    if (nrdy !== 1) begin
      failures++;
      $display("FAIL ready_count dut%0d got=%0d exp=1", i, nrdy);
    end
    checks++;
    if (idle_c !== exp_idle) begin
      failures++;
      $display("FAIL busy_span dut%0d got=%0d exp=%0d", i, idle_c, exp_idle);
    end
    if (wr) begin
      if (a == 8'hFF) ioout_m[i] = d;
      else if (a != 8'hFE) begin mem_m[i][a] = d; mem_v[i][a] = 1'b1; end
    end else begin
      rd_m[i] = exp;
    end
    checks++;
    if (iout[i] !== ioout_m[i]) begin
      failures++;
      $display("FAIL ioout dut%0d got=%h exp=%h", i, iout[i], ioout_m[i]);
    end
    checks++;
    if (rdat[i] !== rd_m[i]) begin
      failures++;
      $display("FAIL read_hold dut%0d got=%h exp=%h", i, rdat[i], rd_m[i]);
    end
    checks++;
    if (err[i] !== err_m[i]) begin
      failures++;
      $display("FAIL err_flag dut%0d got=%b exp=%b", i, err[i], err_m[i]);
    end
  endtask

  task automatic test_reset();
    mr = 3'b000; mw = 3'b000; Addr = 8'h00; WriteData = 16'h0000; IOIn = 16'h0000;
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      ioout_m[i] = 16'h0000; err_m[i] = 1'b0; rd_m[i] = 16'h0000;
      checks++;
      if ({rdy[i], bsy[i], err[i]} !== 3'b000 || rdat[i] !== 16'h0000 || iout[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_state dut%0d got rdy=%b busy=%b err=%b rd=%h io=%h exp all zero",
                 i, rdy[i], bsy[i], err[i], rdat[i], iout[i]);
      end
    end
  endtask

  task automatic test_write_read_w1();
    do_txn(1, 1'b1, 8'h10, 16'h1234, 1);
    do_txn(1, 1'b0, 8'h10, 16'h0000, 1);
    checks++;
    if (rdat[1] !== 16'h1234) begin
      failures++;
      $display("FAIL wr_rd_w1 got=%h exp=1234", rdat[1]);
    end
  endtask

  task automatic test_io_w0();
    IOIn = 16'hBEEF;
    do_txn(0, 1'b0, 8'hFE, 16'h0000, 1);
    checks++;
    if (rdat[0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL io_in_read got=%h exp=beef", rdat[0]);
    end
    do_txn(0, 1'b1, 8'hFF, 16'h00FF, 1);
    checks++;
    if (iout[0] !== 16'h00FF) begin
      failures++;
      $display("FAIL io_out_write got=%h exp=00ff", iout[0]);
    end
    do_txn(0, 1'b0, 8'hFF, 16'h0000, 1);
    do_txn(0, 1'b1, 8'hFE, 16'h5555, 1);
    do_txn(0, 1'b0, 8'hFE, 16'h0000, 1);
  endtask

  task automatic test_both_strobes();
    int nrdy;
    nrdy = 0;
    Addr = 8'h10; WriteData = 16'hDEAD; mr[1] = 1'b1; mw[1] = 1'b1;
    @(posedge CLK);
    #1 mr[1] = 1'b0; mw[1] = 1'b0;
    err_m[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (rdy[1] !== 1'b0 || bsy[1] !== 1'b0) nrdy++;
    end
    checks++;
    if (nrdy !== 0) begin
      failures++;
      $display("FAIL conflict_idle got=%0d active cycles exp=0", nrdy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (err[i] !== err_m[i] || iout[i] !== ioout_m[i]) begin
        failures++;
        $display("FAIL conflict_err dut%0d got err=%b io=%h exp err=%b io=%h",
                 i, err[i], iout[i], err_m[i], ioout_m[i]);
      end
    end
    do_txn(1, 1'b0, 8'h10, 16'h0000, 1);
  endtask

  task automatic test_held_strobe();
    do_txn(1, 1'b0, 8'h10, 16'h0000, 6);
    do_txn(0, 1'b1, 8'h11, 16'h7777, 5);
    do_txn(0, 1'b0, 8'h11, 16'h0000, 3);
  endtask

  task automatic test_reset_abort();
    do_txn(2, 1'b1, 8'h20, 16'h1357, 1);
    do_txn(2, 1'b1, 8'hFF, 16'hC0DE, 1);
    Addr = 8'h20; WriteData = 16'hAAAA; mw[2] = 1'b1;
    @(posedge CLK);
    #1 mw[2] = 1'b0;
    @(posedge CLK);
    #1 Reset = 1'b0;
    @(posedge CLK);
    #1 Reset = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      ioout_m[i] = 16'h0000; err_m[i] = 1'b0; rd_m[i] = 16'h0000;
      checks++;
      if ({rdy[i], bsy[i], err[i]} !== 3'b000 || iout[i] !== 16'h0000 || rdat[i] !== 16'h0000) begin
        failures++;
        $display("FAIL abort_state dut%0d got rdy=%b busy=%b err=%b io=%h rd=%h exp all zero",
                 i, rdy[i], bsy[i], err[i], iout[i], rdat[i]);
      end
    end
    repeat (4) @(negedge CLK);
    do_txn(2, 1'b0, 8'h20, 16'h0000, 1);
    checks++;
    if (rdat[2] !== 16'h1357) begin
      failures++;
      $display("FAIL abort_ram got=%h exp=1357", rdat[2]);
    end
  endtask

  task automatic test_random();
    bit wr;
    int pick;
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 15; n++) begin
        wr   = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 9);
        a    = (pick == 8) ? 8'hFE : ((pick == 9) ? 8'hFF : 8'(8'h30 + pick));
        if (!wr && a < 8'hFE && !mem_v[i][a]) wr = 1'b1;
        IOIn = 16'($urandom);
        do_txn(i, wr, a, 16'($urandom), $urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_w1();
    test_io_w0();
    test_both_strobes();
    test_held_strobe();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the accumulator processor's multicycle control. Serves MemRead/MemWrite strobes and Addr/WriteData from the datapath.
- Owns the unified instruction/data RAM plus two memory-mapped I/O words (input port, output port).
- Inserts a programmable number of wait states and signals completion with a one-cycle Ready pulse, which the stalling control revision waits on.

Parameters:
- ADDR_W, 8, word-address width; RAM depth is 2^ADDR_W words minus the two I/O addresses.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 1, wait states between request acceptance and Ready; legal range 0..15.
- IO_IN_ADDR, 2^ADDR_W-2, read-only address returning IOIn.
- IO_OUT_ADDR, 2^ADDR_W-1, address of the IOOut register (read/write).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- MemRead  input  1  read request strobe.
- MemWrite  input  1  write request strobe.
- Addr  input  ADDR_W  word address, sampled at acceptance.
- WriteData  input  DATA_W  store data, sampled at acceptance.
- IOIn  input  DATA_W  external input port (switches).
- ReadData  output  DATA_W  read result; valid while Ready=1 and held until the next accepted read.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  high in every state except IDLE.
- IOOut  output  DATA_W  output port register.
- Err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state=IDLE; Ready, Busy and Err cleared to 0; ReadData=0; IOOut=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts the request; a pending write never reaches RAM or IOOut.
- States:
  - IDLE: Busy=0.
  - WAIT: counting wait states.
  - DONE: Ready=1 for exactly one cycle.
  - HOLD: waits for the strobes to drop.
- IDLE transitions:
  - Exactly one of MemRead/MemWrite high: latch Addr, WriteData and direction. Next state is WAIT with counter=WAIT_CYCLES-1, or DONE directly if WAIT_CYCLES=0.
  - Both strobes high: set Err, accept nothing, stay IDLE. Err clears only on reset.
  - Neither strobe high: stay IDLE.
- WAIT: decrement counter; at counter=0 go to DONE. Strobes and Addr are ignored while in WAIT.
- Commit on the edge entering DONE:
  - Write to RAM: RAM[addr] <= data.
  - Write to IO_OUT_ADDR: IOOut <= data.
  - Write to IO_IN_ADDR: discarded, no error.
  - Read: ReadData <= RAM[addr], IOIn (sampled this edge) or IOOut, selected by the latched address.
- Latency: request accepted at edge k gives Ready=1 during cycle k+WAIT_CYCLES+1.
- Write commit timing: a read of an address written by the previous transaction returns the new data.
- DONE to HOLD: always go to HOLD. HOLD returns to IDLE on the first edge where both strobes are low. A strobe held continuously is therefore never serviced twice.
- Default: with single-cycle strobes (current control), HOLD lasts exactly one cycle.
- Addr arithmetic: Addr is used unmodified. There is no wrap or offset, and out-of-range is impossible by width.

Test Plan:
1. WAIT_CYCLES=1: write 0x1234 to addr 0x10, then read 0x10.
   - Required: Ready pulses at cycle k+2 of each transaction; ReadData=0x1234; Busy high from k+1 through HOLD.
2. WAIT_CYCLES=0: read with IOIn=0xBEEF at IO_IN_ADDR.
   - Required: Ready at k+1 with ReadData=0xBEEF.
   - Then write 0x00FF to IO_OUT_ADDR. Required: IOOut=0x00FF after the commit edge; read of IO_OUT_ADDR returns 0x00FF.
3. Drive MemRead=1 and MemWrite=1 in IDLE.
   - Required: Err=1, no Ready, RAM and IOOut unchanged.
   - Then a normal read. Required: it completes with Err still 1.
4. Hold MemRead high for 6 cycles at WAIT_CYCLES=1.
   - Required: exactly one Ready pulse; state sits in HOLD until MemRead drops, then returns to IDLE.
5. Write 0xAAAA to addr 0x20 with WAIT_CYCLES=3; assert Reset=0 during the second WAIT cycle.
   - Required after reset: Ready=0, Busy=0, IOOut=0; a later read of 0x20 returns the prior contents, not 0xAAAA.
6. While in WAIT, change Addr and WriteData.
   - Required: the committed transaction uses the values latched at acceptance.
